// File: rtl/emu_pkg.sv
// Shared definitions for the emu GPS synthesizer stages: NCO sample width,
// complex NCO sample type and a width-parameterised saturation helper.
package emu_pkg;

   localparam int NCO_W = 6;

   typedef struct packed {
      logic signed [NCO_W-1:0] re;
      logic signed [NCO_W-1:0] im;
   } cplx_nco_t;

   // Clamp v to the signed range of a w-bit value; the caller keeps the low w bits.
   function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int unsigned w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/emu_cplx_scale.sv
// Stage 1 of the channel combiner: applies the spreading sign and the unsigned
// channel gain to one complex NCO sample and registers the products.
module emu_cplx_scale
   import emu_pkg::*;
#(
   parameter int IN_W   = NCO_W,
   parameter int GAIN_W = 4,
   parameter int PROD_W = IN_W + GAIN_W + 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     code_bit,
   input  logic [GAIN_W-1:0]        gain,
   input  logic signed [IN_W-1:0]   re,
   input  logic signed [IN_W-1:0]   im,
   output logic signed [PROD_W-1:0] re_p1,
   output logic signed [PROD_W-1:0] im_p1
);

   logic signed [IN_W:0]     x_re_p0, x_im_p0;
   logic signed [IN_W:0]     s_re_p0, s_im_p0;
   logic signed [GAIN_W:0]   g_p0;
   logic signed [PROD_W-1:0] m_re_p0, m_im_p0;

   // One guard bit so negating the most negative sample does not wrap.
   always_comb begin
      x_re_p0 = {re[IN_W-1], re};
      x_im_p0 = {im[IN_W-1], im};
      s_re_p0 = code_bit ? -x_re_p0 : x_re_p0;
      s_im_p0 = code_bit ? -x_im_p0 : x_im_p0;
      g_p0    = {1'b0, gain};
      m_re_p0 = PROD_W'(s_re_p0) * PROD_W'(g_p0);
      m_im_p0 = PROD_W'(s_im_p0) * PROD_W'(g_p0);
   end

   // ---- stage 1 register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         re_p1 <= '0;
         im_p1 <= '0;
      end else if (en) begin
         re_p1 <= m_re_p0;
         im_p1 <= m_im_p0;
      end
   end

endmodule

// File: rtl/emu_channel_combiner.sv
// Sums sign/gain-weighted per-channel complex Doppler samples into one composite
// sample per frame. Optional EMU_COMBINER_SAT_CNT_EN adds a saturating overflow counter.
module emu_channel_combiner
   import emu_pkg::*;
#(
   parameter int NUM_CHAN = 12,
   parameter int IN_W     = NCO_W,
   parameter int GAIN_W   = 4,
   parameter int SHIFT    = 2,
   parameter int OUT_W    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        dv_in,
   input  logic [$clog2(NUM_CHAN)-1:0] chan,
   input  logic                        code_bit,
   input  logic [GAIN_W-1:0]           gain,
   input  logic signed [IN_W-1:0]      real_in,
   input  logic signed [IN_W-1:0]      imag_in,
   output logic                        dv_out,
   output logic signed [OUT_W-1:0]     real_out,
   output logic signed [OUT_W-1:0]     imag_out,
   output logic                        overflow,
`ifdef EMU_COMBINER_SAT_CNT_EN
   output logic                        seq_err,
   output logic [15:0]                 sat_count
`else
   output logic                        seq_err
`endif
);

   localparam int CHAN_W = $clog2(NUM_CHAN);
   localparam int PROD_W = IN_W + GAIN_W + 2;
   localparam int ACC_W  = PROD_W + CHAN_W;
   localparam logic [CHAN_W-1:0] LAST = CHAN_W'(NUM_CHAN - 1);

   logic [CHAN_W-1:0]        exp_chan, exp_next;
   logic                     match_p0, accept_p0;
   logic                     vld_p1, first_p1, last_p1;
   logic signed [PROD_W-1:0] re_p1, im_p1;
   logic                     vld_p2;
   logic signed [ACC_W-1:0]  acc_re_p2, acc_im_p2;
   logic signed [ACC_W-1:0]  y_re_p2, y_im_p2;
   logic signed [31:0]       sat_re_p2, sat_im_p2;
   logic                     clip_p2;

   // An out-of-order index drops the frame; only chan 0 may restart one.
   always_comb begin
      match_p0  = (chan == exp_chan);
      accept_p0 = dv_in && (match_p0 || chan == '0);
      exp_next  = exp_chan;
      if (dv_in) begin
         if (!accept_p0 || chan == LAST) exp_next = '0;
         else                            exp_next = chan + CHAN_W'(1);
      end
   end

   emu_cplx_scale #(
      .IN_W   (IN_W),
      .GAIN_W (GAIN_W),
      .PROD_W (PROD_W)
   ) u_scale (
      .clk      (clk),
      .reset    (reset),
      .en       (accept_p0),
      .code_bit (code_bit),
      .gain     (gain),
      .re       (real_in),
      .im       (imag_in),
      .re_p1    (re_p1),
      .im_p1    (im_p1)
   );

   // ---- stage 1 control ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_chan <= '0;
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
         seq_err  <= 1'b0;
      end else begin
         exp_chan <= exp_next;
         vld_p1   <= accept_p0;
         first_p1 <= (chan == '0);
         last_p1  <= (chan == LAST);
         seq_err  <= dv_in && !match_p0;
      end
   end

   // ---- stage 2: frame accumulator ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_re_p2 <= '0;
         acc_im_p2 <= '0;
         vld_p2    <= 1'b0;
      end else begin
         vld_p2 <= vld_p1 && last_p1;
         if (vld_p1) begin
            acc_re_p2 <= (first_p1 ? '0 : acc_re_p2) + ACC_W'(re_p1);
            acc_im_p2 <= (first_p1 ? '0 : acc_im_p2) + ACC_W'(im_p1);
         end
      end
   end

   always_comb begin
      y_re_p2   = acc_re_p2 >>> SHIFT;
      y_im_p2   = acc_im_p2 >>> SHIFT;
      sat_re_p2 = sat(32'(y_re_p2), OUT_W);
      sat_im_p2 = sat(32'(y_im_p2), OUT_W);
      clip_p2   = (sat_re_p2 != 32'(y_re_p2)) || (sat_im_p2 != 32'(y_im_p2));
   end

   // ---- stage 3: scale, saturate, strobe out ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         real_out <= '0;
         imag_out <= '0;
         dv_out   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         dv_out   <= vld_p2;
         overflow <= vld_p2 && clip_p2;
         if (vld_p2) begin
            real_out <= sat_re_p2[OUT_W-1:0];
            imag_out <= sat_im_p2[OUT_W-1:0];
         end
      end
   end

`ifdef EMU_COMBINER_SAT_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                   sat_count <= '0;
      else if (vld_p2 && clip_p2 && sat_count != '1) sat_count <= sat_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_emu_channel_combiner.sv
// Scoreboard bench for emu_channel_combiner: directed frames push expected
// composite samples; a monitor pops and compares on every dv_out strobe.
module tb_emu_channel_combiner;

   localparam int NUM_CHAN = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              dv_in;
   logic [3:0]        chan;
   logic              code_bit;
   logic [3:0]        gain;
   logic signed [5:0] real_in, imag_in;
   logic              dv_out;
   logic signed [7:0] real_out, imag_out;
   logic              overflow;
   logic              seq_err;
`ifdef EMU_COMBINER_SAT_CNT_EN
   logic [15:0]       sat_count;
`endif

   emu_channel_combiner dut (
      .clk      (clk),
      .reset    (reset),
      .dv_in    (dv_in),
      .chan     (chan),
      .code_bit (code_bit),
      .gain     (gain),
      .real_in  (real_in),
      .imag_in  (imag_in),
      .dv_out   (dv_out),
      .real_out (real_out),
      .imag_out (imag_out),
      .overflow (overflow),
`ifdef EMU_COMBINER_SAT_CNT_EN
      .seq_err  (seq_err),
      .sat_count(sat_count)
`else
      .seq_err  (seq_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int re;
      int im;
      int ov;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   seq_seen = 0;
   int   dv_seen = 0;
   int   dv_exp = 0;
   int   last_dv_cyc = 0;
   int   prev_dv_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: outputs are registered, so sampling on the falling edge is stable.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (seq_err) seq_seen++;
         if (dv_out) begin
            dv_seen++;
            prev_dv_cyc = last_dv_cyc;
            last_dv_cyc = cyc;
            if (sbq.size() == 0) begin
               chk("unexpected_dv_out", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("real_out", int'(real_out), e.re);
               chk("imag_out", int'(imag_out), e.im);
               chk("overflow", int'(overflow), e.ov);
               chk("latency", cyc - e.cyc, 3);
            end
         end
      end
   end

   task automatic send(input int c, input bit code, input int g, input int re, input int im,
                       input int gap);
      chan     = 4'(c);
      code_bit = code;
      gain     = 4'(g);
      real_in  = 6'(re);
      imag_in  = 6'(im);
      dv_in    = 1'b1;
      @(negedge clk);
      dv_in = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic expect_out(input int re, input int im, input int ov);
      exp_t e;
      e.re = re; e.im = im; e.ov = ov; e.cyc = cyc;
      sbq.push_back(e);
      dv_exp++;
   endtask

   task automatic frame(input int re, input int im, input bit code, input int g,
                        input int ere, input int eim, input int eov, input int gap);
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (c == NUM_CHAN - 1) expect_out(ere, eim, eov);
         send(c, code, g, re, im, gap);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int s0;
      reset = 1'b1; dv_in = 1'b0; chan = '0; code_bit = 1'b0; gain = '0;
      real_in = '0; imag_in = '0;
      idle(3);
      chk("reset_dv_out", int'(dv_out), 0);
      chk("reset_real_out", int'(real_out), 0);
      chk("reset_imag_out", int'(imag_out), 0);
      chk("reset_overflow", int'(overflow), 0);
      chk("reset_seq_err", int'(seq_err), 0);
      reset = 1'b0;
      idle(2);

      // Back-to-back frames at full rate
      frame(1, 0, 1'b0, 1, 3, 0, 0, 1);
      frame(1, 0, 1'b1, 1, -3, 0, 0, 1);
      frame(31, -32, 1'b0, 15, 127, -128, 1, 1);
      frame(-32, 31, 1'b1, 15, 127, -128, 1, 1);
      frame(14, -14, 1'b0, 3, 42 * 3, -126, 0, 1);
      frame(9, -9, 1'b0, 5, 127, -128, 1, 1);
      frame(-3, 5, 1'b0, 2, -18, 30, 0, 1);

      // Single contributing channel: -1 >>> 2 floors to -1, +1 >>> 2 to 0
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (c == NUM_CHAN - 1) expect_out(-1, 0, 0);
         if (c == 0) send(c, 1'b0, 1, -1, 1, 1);
         else        send(c, 1'b0, 0, 7, -7, 1);
      end
      idle(6);
      chk("hold_real_out", int'(real_out), -1);
      chk("hold_imag_out", int'(imag_out), 0);
      chk("idle_dv_out", int'(dv_out), 0);

      // Skipped index: frame dropped, one seq_err pulse
      s0 = seq_seen;
      for (int c = 0; c < 6; c++) send(c, 1'b0, 1, 1, 0, 1);
      send(7, 1'b0, 1, 1, 0, 1);
      idle(4);
      chk("seq_err_skip", seq_seen - s0, 1);
      frame(1, 0, 1'b0, 1, 3, 0, 0, 1);

      // Early chan 0 restarts the frame; partial sum must not leak in
      s0 = seq_seen;
      for (int c = 0; c < 4; c++) send(c, 1'b0, 7, 5, 5, 1);
      frame(1, 0, 1'b0, 1, 3, 0, 0, 1);
      idle(4);
      chk("seq_err_restart", seq_seen - s0, 1);

`ifdef EMU_COMBINER_SAT_CNT_EN
      chk("sat_count_pre_reset", int'(sat_count), 3);
`endif

      // Reset mid-frame after chan 5
      for (int c = 0; c < 6; c++) send(c, 1'b0, 1, 1, 0, 1);
      reset = 1'b1;
      #1;
      chk("midreset_real_out", int'(real_out), 0);
      chk("midreset_dv_out", int'(dv_out), 0);
`ifdef EMU_COMBINER_SAT_CNT_EN
      chk("midreset_sat_count", int'(sat_count), 0);
`endif
      idle(2);
      reset = 1'b0;
      idle(1);
      frame(1, 0, 1'b0, 1, 3, 0, 0, 1);
      frame(31, -32, 1'b0, 15, 127, -128, 1, 1);

      // Sparse input: one sample every 16 cycles
      frame(1, 0, 1'b0, 1, 3, 0, 0, 16);
      frame(1, 0, 1'b0, 1, 3, 0, 0, 16);
      idle(8);
      chk("sparse_spacing", last_dv_cyc - prev_dv_cyc, NUM_CHAN * 16);

      idle(4);
      chk("pending_expected", sbq.size(), 0);
      chk("dv_out_count", dv_seen, dv_exp);
`ifdef EMU_COMBINER_SAT_CNT_EN
      chk("sat_count_final", int'(sat_count), 1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
